vga_fetch_arbiter: RTL

VGA_FETCH_ARBITER -- requirements
Module: vga_fetch_arbiter

---
 rtl/vga_fetch_arbiter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vga_fetch_arbiter
// Purpose : Shares one single-port memory between the display line prefetch
//           (high priority, burst based) and a processor port. A display line
//           is fetched in bursts of BURST words into a double-banked line
//           buffer. After each burst, one processor access is granted if the
//           processor is waiting.
// Ports   : clk50/reset_n       clock, async active-low reset
//           frame_start         start-of-frame pulse (row counter clear)
//           line_start          line trigger (rising edge only)
//           mem_*               memory master port (req held until ack)
//           p_*                 processor slave port (p_ack one-cycle pulse)
//           lb_*                line-buffer write port
//           overrun, busy       status
// Revision: 1.0 - initial release
// ============================================================================
module vga_fetch_arbiter #(
  parameter int          WORDS = 160,
  parameter int          BURST = 16,
  parameter int          LINES = 480,
  parameter logic [16:0] BASE  = 17'd0
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        line_start,
  output logic        mem_req,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [16:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_ack,
  output logic [31:0] p_rdata,
  output logic        lb_we,
  output logic        lb_bank,
  output logic [7:0]  lb_addr,
  output logic [31:0] lb_data,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_PROC = 2'd2
  } state_t;

  localparam logic [7:0]  LAST_WORD = 8'(WORDS - 1);
  localparam logic [7:0]  LAST_BEAT = 8'(BURST - 1);
  localparam logic [8:0]  NUM_LINES = 9'(LINES);
  localparam logic [16:0] WORDS17   = 17'(WORDS);

  state_t      state, state_nx;
  logic [8:0]  frow, frow_nx;
  logic [8:0]  row, row_nx;
  logic [8:0]  arm_row, arm_row_nx;
  logic [7:0]  widx, widx_nx;
  logic [7:0]  beat, beat_nx;
  logic        busy_nx, overrun_nx;
  logic        owed, owed_nx;
  logic        stop_pend, stop_pend_nx;
  logic        arm_pend, arm_pend_nx;
  logic        ls_d, started;

  logic        disp_ack, last_word, line_edge, accept;
  logic [8:0]  frow_eff;
  logic [16:0] disp_addr;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      frow      <= '0;
      row       <= '0;
      arm_row   <= '0;
      widx      <= '0;
      beat      <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      owed      <= 1'b0;
      stop_pend <= 1'b0;
      arm_pend  <= 1'b0;
      ls_d      <= 1'b0;
      started   <= 1'b0;
    end else begin
      state     <= state_nx;
      frow      <= frow_nx;
      row       <= row_nx;
      arm_row   <= arm_row_nx;
      widx      <= widx_nx;
      beat      <= beat_nx;
      busy      <= busy_nx;
      overrun   <= overrun_nx;
      owed      <= owed_nx;
      stop_pend <= stop_pend_nx;
      arm_pend  <= arm_pend_nx;
      ls_d      <= line_start;
      started   <= 1'b1;
    end
  end

  always_comb begin
    state_nx     = state;
    frow_nx      = frow;
    row_nx       = row;
    arm_row_nx   = arm_row;
    widx_nx      = widx;
    beat_nx      = beat;
    busy_nx      = busy;
    overrun_nx   = overrun;
    owed_nx      = owed;
    stop_pend_nx = stop_pend;
    arm_pend_nx  = arm_pend;

    disp_ack  = (state == ST_DISP) && mem_ack;
    last_word = (widx == LAST_WORD);
    // 'started' masks a line_start that is already high when reset releases
    line_edge = started && line_start && !ls_d;
    frow_eff  = frame_start ? 9'd0 : frow;
    accept    = line_edge && (frow_eff < NUM_LINES);

    case (state)
      ST_IDLE: begin
        // An owed grant is only honoured if the processor is still asking
        owed_nx = 1'b0;
        if (busy && !(owed && p_req)) state_nx = ST_DISP;
        else if (p_req)               state_nx = ST_PROC;
      end
      ST_PROC: begin
        if (mem_ack) state_nx = ST_IDLE;
      end
      ST_DISP: begin
        if (mem_ack) begin
          widx_nx = widx + 8'd1;
          beat_nx = beat + 8'd1;
          if (last_word || stop_pend) begin
            // Line finished or abandoned; a deferred re-arm takes over here
            busy_nx      = arm_pend;
            row_nx       = arm_pend ? arm_row : row;
            widx_nx      = '0;
            stop_pend_nx = 1'b0;
            arm_pend_nx  = 1'b0;
            beat_nx      = '0;
            owed_nx      = 1'b1;
            state_nx     = ST_IDLE;
          end else if (beat == LAST_BEAT) begin
            beat_nx  = '0;
            owed_nx  = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (frame_start) begin
      frow_nx     = '0;
      overrun_nx  = 1'b0;
      arm_pend_nx = 1'b0;
      // A word still in flight must land before the line is dropped
      if ((state == ST_DISP) && !mem_ack) begin
        stop_pend_nx = busy;
      end else begin
        busy_nx      = 1'b0;
        stop_pend_nx = 1'b0;
      end
    end

    if (accept) begin
      frow_nx = frow_eff + 9'd1;
      if (busy && !stop_pend && !(disp_ack && last_word)) overrun_nx = 1'b1;
      if ((state == ST_DISP) && !mem_ack) begin
        // Keep the current row/widx for the in-flight ack, switch afterwards
        arm_pend_nx  = 1'b1;
        arm_row_nx   = frow_eff;
        stop_pend_nx = 1'b1;
      end else begin
        busy_nx      = 1'b1;
        row_nx       = frow_eff;
        widx_nx      = '0;
        stop_pend_nx = 1'b0;
        arm_pend_nx  = 1'b0;
      end
    end

    // Never issue a display request without a live fetch, and restart
    // bursting cleanly when a new row replaced the old one mid-burst
    if ((state_nx == ST_DISP) && (!busy_nx || (disp_ack && accept))) begin
      state_nx = ST_IDLE;
      beat_nx  = '0;
    end
  end

  assign disp_addr = BASE + ({8'd0, row} * WORDS17) + {9'd0, widx};

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    p_ack     = 1'b0;
    p_rdata   = '0;
    lb_we     = 1'b0;
    lb_bank   = 1'b0;
    lb_addr   = '0;
    lb_data   = '0;
    case (state)
      ST_DISP: begin
        mem_req  = 1'b1;
        mem_addr = disp_addr;
        lb_we    = mem_ack;
        lb_bank  = row[0];
        lb_addr  = widx;
        lb_data  = mem_rdata;
      end
      ST_PROC: begin
        mem_req   = 1'b1;
        mem_we    = p_we;
        mem_addr  = p_addr;
        mem_wdata = p_wdata;
        p_ack     = mem_ack;
        p_rdata   = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
